// File: rtl/mult_bus_ctrl.sv
// Bus master/arbiter for the shared shift-add multiplier: round-robin job grant,
// operand write, start pulse, ready handshake, product read. Optional timeout: MULT_TIMEOUT_EN.
module mult_bus_ctrl #(
  parameter int N          = 8,
  parameter int START_HOLD = 3400,
  parameter int TIMEOUT    = 65535
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic [1:0]     req,
  input  logic [N-1:0]   opm_0,
  input  logic [N-1:0]   opq_0,
  input  logic [N-1:0]   opm_1,
  input  logic [N-1:0]   opq_1,
  output logic [1:0]     ack,
  output logic [2*N-1:0] product,
  output logic           err,
  output logic [1:0]     mul_func,
  output logic           mul_oe,
  output logic           mul_start_n,
  input  logic           mul_ready,
  inout  wire  [N-1:0]   mul_data,
  output logic [3:0]     dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WR_M    = 4'd1,
    S_WR_Q    = 4'd2,
    S_START   = 4'd3,
    S_WAIT_LO = 4'd4,
    S_WAIT_HI = 4'd5,
    S_RD_LO   = 4'd6,
    S_RD_HI   = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  // One counter serves the start hold, the two-cycle reads and the wait timeout.
  localparam int CMAX = (START_HOLD > TIMEOUT) ? START_HOLD : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           cnt_clr, cnt_inc;
  logic           id, rr, grant, take;
  logic           lo_take, hi_take, bus_en;
  logic [N-1:0]   m_lat, q_lat, lo_buf;
`ifdef MULT_TIMEOUT_EN
  logic           tmo, tmo_set;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    grant       = rr;
    take        = 1'b0;
    lo_take     = 1'b0;
    hi_take     = 1'b0;
    bus_en      = 1'b0;
    mul_func    = 2'b10;
    mul_oe      = 1'b0;
    mul_start_n = 1'b1;
`ifdef MULT_TIMEOUT_EN
    tmo_set     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (req != 2'b00) begin
          take      = 1'b1;
          grant     = (req == 2'b11) ? rr : req[1];
          state_nxt = S_WR_M;
        end
      end
      S_WR_M: begin
        mul_func  = 2'b00;
        bus_en    = 1'b1;
        state_nxt = S_WR_Q;
      end
      S_WR_Q: begin
        mul_func  = 2'b01;
        bus_en    = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = S_START;
      end
      S_START: begin
        mul_start_n = 1'b0;
        if (cnt == CW'(START_HOLD - 1)) begin
          cnt_clr   = 1'b1;
          state_nxt = S_WAIT_LO;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!mul_ready) begin
          cnt_clr   = 1'b1;
          state_nxt = S_WAIT_HI;
        end
`ifdef MULT_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          tmo_set   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
`endif
      end
      S_WAIT_HI: begin
        if (mul_ready) begin
          cnt_clr   = 1'b1;
          state_nxt = S_RD_LO;
        end
`ifdef MULT_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          tmo_set   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
`endif
      end
      S_RD_LO: begin
        mul_oe = 1'b1;
        if (cnt == CW'(1)) begin
          lo_take   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = S_RD_HI;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_RD_HI: begin
        mul_oe   = 1'b1;
        mul_func = 2'b11;
        if (cnt == CW'(1)) begin
          hi_take   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      id      <= 1'b0;
      rr      <= 1'b0;
      m_lat   <= '0;
      q_lat   <= '0;
      lo_buf  <= '0;
      product <= '0;
`ifdef MULT_TIMEOUT_EN
      tmo     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CW'(1);
      if (take) begin
        id    <= grant;
        rr    <= ~grant;
        m_lat <= grant ? opm_1 : opm_0;
        q_lat <= grant ? opq_1 : opq_0;
`ifdef MULT_TIMEOUT_EN
        tmo   <= 1'b0;
`endif
      end
      if (lo_take) lo_buf  <= mul_data;
      if (hi_take) product <= {mul_data, lo_buf};
`ifdef MULT_TIMEOUT_EN
      if (tmo_set) begin
        tmo     <= 1'b1;
        product <= '0;
      end
`endif
    end
  end

  // Outputs decode the state directly so an async reset takes the bus idle at once.
  assign mul_data  = bus_en ? ((state == S_WR_M) ? m_lat : q_lat) : {N{1'bz}};
  assign ack       = (state == S_DONE) ? (id ? 2'b10 : 2'b01) : 2'b00;
`ifdef MULT_TIMEOUT_EN
  assign err       = (state == S_DONE) && tmo;
`else
  assign err       = 1'b0;
`endif
  assign dbg_state = state;

endmodule

// File: tb/tb_mult_bus_ctrl.sv
// Directed bench for mult_bus_ctrl with a behavioural multiplier on the shared bus.
module tb_mult_bus_ctrl;
  localparam int N  = 8;
  localparam int SH = 5;
  localparam int TO = 16;
  localparam logic [3:0] S_IDLE = 4'd0, S_WR_M = 4'd1, S_WR_Q = 4'd2,
                         S_WAIT_LO = 4'd4, S_WAIT_HI = 4'd5;

  // clock / reset
  logic osc_clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 osc_clk = ~osc_clk;

  logic [1:0]   req = 2'b00;
  logic [N-1:0] opm_0 = '0, opq_0 = '0, opm_1 = '0, opq_1 = '0;
  logic [1:0]   ack;
  logic [15:0]  product;
  logic         err;
  logic [1:0]   mul_func;
  logic         mul_oe, mul_start_n, mul_ready;
  wire  [N-1:0] mul_data;
  logic [3:0]   dbg_state;

  mult_bus_ctrl #(.N(N), .START_HOLD(SH), .TIMEOUT(TO)) dut (
    .clk(osc_clk), .n_reset(n_reset), .req(req),
    .opm_0(opm_0), .opq_0(opq_0), .opm_1(opm_1), .opq_1(opq_1),
    .ack(ack), .product(product), .err(err),
    .mul_func(mul_func), .mul_oe(mul_oe), .mul_start_n(mul_start_n),
    .mul_ready(mul_ready), .mul_data(mul_data), .dbg_state(dbg_state)
  );

  // multiplier model: latch M/Q on func 00/01, accept after start release, finish later
  logic [7:0]  mm, mq;
  logic [15:0] mprod;
  logic        mready, stuck;
  int          mphase, mcnt;
  initial stuck = 1'b0;
  always @(posedge osc_clk or negedge n_reset) begin
    if (!n_reset) begin
      mm <= '0; mq <= '0; mprod <= '0; mready <= 1'b1; mphase <= 0; mcnt <= 0;
    end else begin
      if (mul_func == 2'b00) mm <= mul_data;
      if (mul_func == 2'b01) mq <= mul_data;
      case (mphase)
        0: if (!mul_start_n) mphase <= 1;
        1: if (mul_start_n) begin mphase <= 2; mcnt <= 0; end
        2: if (mcnt == 1) begin mready <= 1'b0; mphase <= 3; mcnt <= 0; end
           else mcnt <= mcnt + 1;
        default: if (mcnt == 3) begin
                   mready <= 1'b1; mprod <= {8'h00, mm} * {8'h00, mq}; mphase <= 0;
                 end else mcnt <= mcnt + 1;
      endcase
    end
  end
  assign mul_ready = stuck ? 1'b1 : mready;
  assign mul_data  = mul_oe ? ((mul_func == 2'b11) ? mprod[15:8] : mprod[7:0]) : 8'bz;

  // bus monitor
  int bus_viol = 0, f00_cnt = 0, f01_cnt = 0, wlo_cnt = 0;
  logic [7:0] cur_m = '0;
  always @(negedge osc_clk) begin
    if (n_reset) begin
      if (mul_func == 2'b00) f00_cnt++;
      if (mul_func == 2'b01) f01_cnt++;
      if (dbg_state == S_WAIT_LO) wlo_cnt++;
      if (mul_oe && (dbg_state == S_WR_M || dbg_state == S_WR_Q)) bus_viol++;
      if (mul_func == 2'b00 && dbg_state != S_WR_M) bus_viol++;
      if (mul_func == 2'b01 && dbg_state != S_WR_Q) bus_viol++;
      if (dbg_state == S_WR_M && mul_data !== cur_m) bus_viol++;
    end
  end

  // scoreboard
  int n_chk = 0, n_err = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ack(output logic [1:0] a, output logic [15:0] p, output logic e);
    bit seen;
    seen = 1'b0; a = '0; p = '0; e = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge osc_clk);
      if (ack != 2'b00) begin
        seen = 1'b1; a = ack; p = product; e = err;
      end
    end
    check("ack_seen", {31'd0, seen}, 32'd1);
  endtask

  typedef struct {
    logic [1:0]  rq;
    logic [7:0]  m0, q0, m1, q1;
    logic [1:0]  exp_ack;
    logic [15:0] exp_p;
  } vec_t;
  vec_t vt[6];

  logic [1:0]  a;
  logic [15:0] p;
  logic        e;
  int          s00, s01, swl, nack;
  bit          hit;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{2'b01, 8'h0C, 8'h0A, 8'hAA, 8'h55, 2'b01, 16'h0078};
    vt[1] = '{2'b10, 8'h33, 8'h44, 8'hFF, 8'hFF, 2'b10, 16'hFE01};
    vt[2] = '{2'b01, 8'h00, 8'h5A, 8'h11, 8'h22, 2'b01, 16'h0000};
    vt[3] = '{2'b01, 8'hFF, 8'h01, 8'h11, 8'h22, 2'b01, 16'h00FF};
    vt[4] = '{2'b10, 8'h66, 8'h77, 8'h80, 8'h02, 2'b10, 16'h0100};
    vt[5] = '{2'b10, 8'h09, 8'h09, 8'h37, 8'h1D, 2'b10, 16'h063B};

    // reset state
    #3;
    check("rst_state", {28'd0, dbg_state}, {28'd0, S_IDLE});
    check("rst_product", {16'd0, product}, 32'd0);
    check("rst_ack", {30'd0, ack}, 32'd0);
    check("rst_func", {30'd0, mul_func}, 32'd2);
    check("rst_oe", {31'd0, mul_oe}, 32'd0);
    check("rst_start_n", {31'd0, mul_start_n}, 32'd1);
    repeat (3) @(negedge osc_clk);
    n_reset = 1'b1;
    @(negedge osc_clk);

    // single-requester jobs from the table
    for (int i = 0; i < 6; i++) begin
      opm_0 = vt[i].m0; opq_0 = vt[i].q0; opm_1 = vt[i].m1; opq_1 = vt[i].q1;
      cur_m = vt[i].rq[1] ? vt[i].m1 : vt[i].m0;
      s00 = f00_cnt; s01 = f01_cnt;
      req = vt[i].rq;
      wait_ack(a, p, e);
      req = 2'b00;
      check($sformatf("vec%0d_ack", i), {30'd0, a}, {30'd0, vt[i].exp_ack});
      check($sformatf("vec%0d_product", i), {16'd0, p}, {16'd0, vt[i].exp_p});
      check($sformatf("vec%0d_err", i), {31'd0, e}, 32'd0);
      check($sformatf("vec%0d_func00_cycles", i), f00_cnt - s00, 32'd1);
      check($sformatf("vec%0d_func01_cycles", i), f01_cnt - s01, 32'd1);
    end

    // both requesting for three jobs: round-robin 0,1,0
    opm_0 = 8'h02; opq_0 = 8'h03; opm_1 = 8'h04; opq_1 = 8'h05;
    for (int j = 0; j < 3; j++) begin
      cur_m = (j == 1) ? 8'h04 : 8'h02;
      req = 2'b11;
      wait_ack(a, p, e);
      if (j == 2) req = 2'b00;
      check($sformatf("rr%0d_ack", j), {30'd0, a}, (j == 1) ? 32'd2 : 32'd1);
      check($sformatf("rr%0d_product", j), {16'd0, p}, (j == 1) ? 32'h14 : 32'h06);
      check($sformatf("rr%0d_err", j), {31'd0, e}, 32'd0);
    end

`ifdef MULT_TIMEOUT_EN
    // ready stuck high: timeout after TO cycles in WAIT_LO
    stuck = 1'b1;
    opm_0 = 8'h03; opq_0 = 8'h03; cur_m = 8'h03;
    swl = wlo_cnt;
    req = 2'b01;
    wait_ack(a, p, e);
    req = 2'b00;
    check("tmo_ack", {30'd0, a}, 32'd1);
    check("tmo_err", {31'd0, e}, 32'd1);
    check("tmo_product", {16'd0, p}, 32'd0);
    check("tmo_wait_lo_cycles", wlo_cnt - swl, TO);
    stuck = 1'b0;
    repeat (12) @(negedge osc_clk);
`endif

    // async reset while waiting for the multiplier to finish
    opm_0 = 8'h07; opq_0 = 8'h09; cur_m = 8'h07;
    req = 2'b01;
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge osc_clk);
      if (dbg_state == S_WAIT_HI) hit = 1'b1;
    end
    check("reach_wait_hi", {31'd0, hit}, 32'd1);
    #1 n_reset = 1'b0; req = 2'b00;
    #1;
    check("midrst_start_n", {31'd0, mul_start_n}, 32'd1);
    check("midrst_oe", {31'd0, mul_oe}, 32'd0);
    check("midrst_func", {30'd0, mul_func}, 32'd2);
    check("midrst_ack", {30'd0, ack}, 32'd0);
    check("midrst_state", {28'd0, dbg_state}, {28'd0, S_IDLE});
    check("midrst_product", {16'd0, product}, 32'd0);
    repeat (2) @(negedge osc_clk);
    n_reset = 1'b1;
    nack = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge osc_clk);
      if (ack != 2'b00) nack++;
    end
    check("midrst_no_ack", nack, 32'd0);

    check("bus_violations", bus_viol, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
